// File: rtl/bp_cacc_pkg.sv
// Shared definitions for the vector-dot-product accelerator CSR window and its job scheduler.
package bp_cacc_pkg;

  localparam logic [11:0] CSR_A_PTR   = 12'h000;
  localparam logic [11:0] CSR_B_PTR   = 12'h040;
  localparam logic [11:0] CSR_LEN     = 12'h080;
  localparam logic [11:0] CSR_START   = 12'h0C0;
  localparam logic [11:0] CSR_STATUS  = 12'h100;
  localparam logic [11:0] CSR_RES_PTR = 12'h140;

  localparam logic [63:0] STATUS_BUSY = 64'h0;
  localparam logic [63:0] STATUS_IDLE = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] STATUS_DONE = 64'h1;

  // Command steps 0..4 program the tile; step 5 is the status poll.
  localparam logic [2:0] STEP_START  = 3'd4;
  localparam logic [2:0] STEP_STATUS = 3'd5;

  typedef enum logic [2:0] {
    e_idle, e_grant, e_issue, e_wait_resp, e_poll_gap, e_cpl
  } bp_cacc_sched_state_e;

  function automatic logic [11:0] step_offset(input logic [2:0] step);
    case (step)
      3'd0:    step_offset = CSR_A_PTR;
      3'd1:    step_offset = CSR_B_PTR;
      3'd2:    step_offset = CSR_LEN;
      3'd3:    step_offset = CSR_RES_PTR;
      3'd4:    step_offset = CSR_START;
      default: step_offset = CSR_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Combinational round-robin pick: first requester at or after ptr_i wins.
module bsg_arb_round_robin #(
  parameter int width_p = 4,
  localparam int id_w_lp = $clog2(width_p)
) (
  input  logic [width_p-1:0] reqs_i,
  input  logic [id_w_lp-1:0] ptr_i,
  output logic               v_o,
  output logic [id_w_lp-1:0] id_o,
  output logic [width_p-1:0] grant_o
);

  logic [id_w_lp-1:0] idx;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    v_o     = 1'b0;
    id_o    = '0;
    grant_o = '0;
    idx     = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      idx = id_w_lp'((int'(ptr_i) + k) % width_p);
      if (reqs_i[idx]) begin
        v_o  = 1'b1;
        id_o = idx;
      end
    end
    if (v_o) grant_o[id_o] = 1'b1;
  end

endmodule

// File: rtl/bp_cacc_vdp_sched.sv
// Shares one dot-product tile among requesters: grants a job, programs the tile over CSRs,
// polls status until done or timeout, and returns a tagged completion.
module bp_cacc_vdp_sched
  import bp_cacc_pkg::*;
#(
  parameter int num_req_p        = 4,
  parameter int addr_width_p     = 39,
  parameter int csr_addr_width_p = 20,
  parameter int max_len_p        = 8,
  parameter int poll_gap_p       = 4,
  parameter int timeout_p        = 1024,
  localparam int id_w_lp   = $clog2(num_req_p),
  localparam int poll_w_lp = $clog2(timeout_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_o,
  input  logic [num_req_p*addr_width_p-1:0] req_a_ptr_i,
  input  logic [num_req_p*addr_width_p-1:0] req_b_ptr_i,
  input  logic [num_req_p*addr_width_p-1:0] req_res_ptr_i,
  input  logic [num_req_p*4-1:0]            req_len_i,
  output logic                              csr_v_o,
  output logic                              csr_w_o,
  output logic [csr_addr_width_p-1:0]       csr_addr_o,
  output logic [63:0]                       csr_data_o,
  input  logic                              csr_ready_i,
  input  logic                              csr_resp_v_i,
  input  logic [63:0]                       csr_resp_data_i,
  output logic                              done_v_o,
  output logic [id_w_lp-1:0]                done_id_o,
  output logic                              done_err_o,
  input  logic                              done_yumi_i
);

  bp_cacc_sched_state_e        state_q, state_d;
  logic [id_w_lp-1:0]          ptr_q, ptr_d, owner_q, owner_d;
  logic [num_req_p-1:0]        ready_q, ready_d;
  logic [addr_width_p-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]                  len_q, len_d;
  logic [2:0]                  step_q, step_d;
  logic                        early_q, early_d, seen_busy_q, seen_busy_d;
  logic [63:0]                 rdata_q, rdata_d;
  logic [poll_w_lp-1:0]        poll_cnt_q, poll_cnt_d, poll_inc;
  logic [7:0]                  gap_q, gap_d;
  logic                        csr_v_q, csr_v_d, csr_w_q, csr_w_d;
  logic [csr_addr_width_p-1:0] csr_addr_q, csr_addr_d;
  logic [63:0]                 csr_data_q, csr_data_d;
  logic                        done_v_q, done_v_d, done_err_q, done_err_d;

  logic                        arb_v;
  logic [id_w_lp-1:0]          arb_id;
  logic [num_req_p-1:0]        arb_grant;
  logic                        accept, len_bad, resp_fire;
  logic [3:0]                  sel_len;
  logic [addr_width_p-1:0]     sel_a, sel_b, sel_res;
  logic [63:0]                 resp_data;

  bsg_arb_round_robin #(.width_p(num_req_p)) arb (
    .reqs_i (req_v_i),
    .ptr_i  (ptr_q),
    .v_o    (arb_v),
    .id_o   (arb_id),
    .grant_o(arb_grant)
  );

  function automatic logic [63:0] cmd_data(input logic [2:0] step,
                                           input logic [addr_width_p-1:0] a, b, res,
                                           input logic [3:0] len);
    case (step)
      3'd0:    cmd_data = 64'(a);
      3'd1:    cmd_data = 64'(b);
      3'd2:    cmd_data = 64'(len);
      3'd3:    cmd_data = 64'(res);
      3'd4:    cmd_data = 64'd1;
      default: cmd_data = '0;
    endcase
  endfunction

  assign sel_len   = req_len_i[owner_q*4 +: 4];
  assign sel_a     = req_a_ptr_i[owner_q*addr_width_p +: addr_width_p];
  assign sel_b     = req_b_ptr_i[owner_q*addr_width_p +: addr_width_p];
  assign sel_res   = req_res_ptr_i[owner_q*addr_width_p +: addr_width_p];
  assign accept    = (state_q == e_grant) && req_v_i[owner_q] && ready_q[owner_q];
  assign len_bad   = (sel_len == 4'd0) || (32'(sel_len) > max_len_p);
  // A response that arrived together with the accept is parked in early_q/rdata_q.
  assign resp_fire = (state_q == e_wait_resp) && (early_q || csr_resp_v_i);
  assign resp_data = early_q ? rdata_q : csr_resp_data_i;
  assign poll_inc  = (poll_cnt_q == {poll_w_lp{1'b1}}) ? poll_cnt_q : poll_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    ready_d     = '0;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    len_d       = len_q;
    step_d      = step_q;
    early_d     = early_q;
    seen_busy_d = seen_busy_q;
    rdata_d     = rdata_q;
    poll_cnt_d  = poll_cnt_q;
    gap_d       = gap_q;
    csr_v_d     = csr_v_q;
    csr_w_d     = csr_w_q;
    csr_addr_d  = csr_addr_q;
    csr_data_d  = csr_data_q;
    done_v_d    = done_v_q;
    done_err_d  = done_err_q;
    case (state_q)
      e_idle: if (arb_v) begin
        ready_d = arb_grant;
        owner_d = arb_id;
        state_d = e_grant;
      end
      e_grant: if (accept) begin
        a_d         = sel_a;
        b_d         = sel_b;
        res_d       = sel_res;
        len_d       = sel_len;
        ptr_d       = (owner_q == id_w_lp'(num_req_p - 1)) ? '0 : owner_q + 1'b1;
        step_d      = 3'd0;
        seen_busy_d = 1'b0;
        poll_cnt_d  = '0;
        if (len_bad) begin
          done_v_d   = 1'b1;
          done_err_d = 1'b1;
          state_d    = e_cpl;
        end else begin
          csr_v_d    = 1'b1;
          csr_w_d    = 1'b1;
          csr_addr_d = csr_addr_width_p'(CSR_A_PTR);
          csr_data_d = 64'(sel_a);
          state_d    = e_issue;
        end
      end else begin
        state_d = e_idle;
      end
      e_issue: if (csr_ready_i) begin
        csr_v_d = 1'b0;
        early_d = csr_resp_v_i;
        rdata_d = csr_resp_data_i;
        state_d = e_wait_resp;
      end
      e_wait_resp: if (resp_fire) begin
        early_d = 1'b0;
        if (step_q == STEP_STATUS) begin
          poll_cnt_d = poll_inc;
          if (resp_data == STATUS_BUSY) seen_busy_d = 1'b1;
          if (resp_data != STATUS_BUSY && seen_busy_q) begin
            done_v_d   = 1'b1;
            done_err_d = 1'b0;
            state_d    = e_cpl;
          end else if (poll_inc >= poll_w_lp'(timeout_p)) begin
            done_v_d   = 1'b1;
            done_err_d = 1'b1;
            state_d    = e_cpl;
          end else begin
            gap_d   = '0;
            state_d = e_poll_gap;
          end
        end else if (step_q == STEP_START) begin
          gap_d   = '0;
          state_d = e_poll_gap;
        end else begin
          step_d     = step_q + 3'd1;
          csr_v_d    = 1'b1;
          csr_w_d    = 1'b1;
          csr_addr_d = csr_addr_width_p'(step_offset(step_q + 3'd1));
          csr_data_d = cmd_data(step_q + 3'd1, a_q, b_q, res_q, len_q);
          state_d    = e_issue;
        end
      end
      e_poll_gap: if (gap_q == 8'(poll_gap_p - 1)) begin
        step_d     = STEP_STATUS;
        csr_v_d    = 1'b1;
        csr_w_d    = 1'b0;
        csr_addr_d = csr_addr_width_p'(CSR_STATUS);
        csr_data_d = '0;
        state_d    = e_issue;
      end else begin
        gap_d = gap_q + 8'd1;
      end
      e_cpl: if (done_yumi_i) begin
        done_v_d   = 1'b0;
        done_err_d = 1'b0;
        state_d    = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      ptr_q       <= '0;
      owner_q     <= '0;
      ready_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      len_q       <= '0;
      step_q      <= '0;
      early_q     <= 1'b0;
      seen_busy_q <= 1'b0;
      rdata_q     <= '0;
      poll_cnt_q  <= '0;
      gap_q       <= '0;
      csr_v_q     <= 1'b0;
      csr_w_q     <= 1'b0;
      csr_addr_q  <= '0;
      csr_data_q  <= '0;
      done_v_q    <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      ready_q     <= ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      len_q       <= len_d;
      step_q      <= step_d;
      early_q     <= early_d;
      seen_busy_q <= seen_busy_d;
      rdata_q     <= rdata_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_q       <= gap_d;
      csr_v_q     <= csr_v_d;
      csr_w_q     <= csr_w_d;
      csr_addr_q  <= csr_addr_d;
      csr_data_q  <= csr_data_d;
      done_v_q    <= done_v_d;
      done_err_q  <= done_err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign csr_v_o     = csr_v_q;
  assign csr_w_o     = csr_w_q;
  assign csr_addr_o  = csr_addr_q;
  assign csr_data_o  = csr_data_q;
  assign done_v_o    = done_v_q;
  assign done_id_o   = owner_q;
  assign done_err_o  = done_err_q;

endmodule

// File: tb/tb_bp_cacc_vdp_sched.sv
// Scoreboard bench: a CSR-side tile model checks every command and completion against queues
// filled when each job is submitted.
module tb_bp_cacc_vdp_sched;
  import bp_cacc_pkg::*;

  localparam int N  = 4;
  localparam int AW = 39;

  logic              clk = 1'b0;
  logic              reset_n_i = 1'b0;
  logic [N-1:0]      req_v_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [N*AW-1:0]   req_a_ptr_i = '0, req_b_ptr_i = '0, req_res_ptr_i = '0;
  logic [N*4-1:0]    req_len_i = '0;
  logic              csr_v_o, csr_w_o;
  logic [19:0]       csr_addr_o;
  logic [63:0]       csr_data_o;
  logic              csr_ready_i = 1'b0, csr_resp_v_i = 1'b0;
  logic [63:0]       csr_resp_data_i = '0;
  logic              done_v_o, done_err_o;
  logic [1:0]        done_id_o;
  logic              done_yumi_i = 1'b0;

  bp_cacc_vdp_sched #(.num_req_p(N), .addr_width_p(AW), .csr_addr_width_p(20), .max_len_p(8),
                      .poll_gap_p(4), .timeout_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
    .req_a_ptr_i(req_a_ptr_i), .req_b_ptr_i(req_b_ptr_i), .req_res_ptr_i(req_res_ptr_i),
    .req_len_i(req_len_i), .csr_v_o(csr_v_o), .csr_w_o(csr_w_o), .csr_addr_o(csr_addr_o),
    .csr_data_o(csr_data_o), .csr_ready_i(csr_ready_i), .csr_resp_v_i(csr_resp_v_i),
    .csr_resp_data_i(csr_resp_data_i), .done_v_o(done_v_o), .done_id_o(done_id_o),
    .done_err_o(done_err_o), .done_yumi_i(done_yumi_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, starts_seen = 0, stall = 0;
  logic zero_lat = 1'b0, bp_armed = 1'b0, pend = 1'b0;
  logic [63:0] stuck_val = '0, pend_data = '0, m_rd, m_st;
  logic [84:0] m_got, m_e;
  logic [2:0]  m_d;
  logic [84:0] exp_cmd[$];
  logic [2:0]  exp_done[$];
  logic [63:0] status_q[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [84:0] mk(input logic w, input logic [11:0] off, input logic [63:0] d);
    return {w, 20'(off), d};
  endfunction

  task automatic push_job(input int id, input logic [AW-1:0] a, b, res, input logic [3:0] len,
                          input int nreads, input logic err);
    exp_cmd.push_back(mk(1'b1, CSR_A_PTR, 64'(a)));
    exp_cmd.push_back(mk(1'b1, CSR_B_PTR, 64'(b)));
    exp_cmd.push_back(mk(1'b1, CSR_LEN, 64'(len)));
    exp_cmd.push_back(mk(1'b1, CSR_RES_PTR, 64'(res)));
    exp_cmd.push_back(mk(1'b1, CSR_START, 64'd1));
    repeat (nreads) exp_cmd.push_back(mk(1'b0, CSR_STATUS, 64'd0));
    exp_done.push_back({2'(id), err});
  endtask

  task automatic set_desc(input int id, input logic [AW-1:0] a, b, res, input logic [3:0] len);
    req_a_ptr_i[id*AW +: AW]   = a;
    req_b_ptr_i[id*AW +: AW]   = b;
    req_res_ptr_i[id*AW +: AW] = res;
    req_len_i[id*4 +: 4]       = len;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp_grant);
    int n = 0;
    while (req_ready_o == '0 && n < 3000) begin @(negedge clk); n++; end
    chk("grant", req_ready_o, exp_grant);
  endtask

  task automatic submit(input int id);
    req_v_i[id] = 1'b1;
    wait_grant(N'(1 << id));
    @(posedge clk); #1;
    req_v_i[id] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge clk); n++; end
    chk("job_done", done_cnt, target);
    chk("cmdq_empty", exp_cmd.size(), 0);
  endtask

  // Tile model: decides ready/response for the coming edge and checks what the DUT presents.
  always @(negedge clk) begin
    if (!reset_n_i) begin
      csr_ready_i = 1'b0; csr_resp_v_i = 1'b0; done_yumi_i = 1'b0; pend = 1'b0; stall = 0;
    end else begin
      csr_ready_i = 1'b0; csr_resp_v_i = 1'b0; done_yumi_i = 1'b0;
      if (pend) begin csr_resp_v_i = 1'b1; csr_resp_data_i = pend_data; pend = 1'b0; end
      if (csr_v_o) begin
        m_got = {csr_w_o, csr_addr_o, csr_data_o};
        m_rd  = '0;
        if (exp_cmd.size() == 0) begin
          chk("csr_unexp", exp_cmd.size(), 1);
          csr_ready_i = 1'b1;
        end else begin
          m_e = exp_cmd[0];
          if (bp_armed && m_e[83:64] == 20'(CSR_LEN)) begin bp_armed = 1'b0; stall = 5; end
          if (stall > 0) begin
            stall--;
            chk("bp_hold", m_got, m_e);
          end else begin
            csr_ready_i = 1'b1;
            chk("csr_cmd", m_got, m_e);
            void'(exp_cmd.pop_front());
            if (!m_e[84]) begin
              if (status_q.size() > 0) begin m_st = status_q.pop_front(); m_rd = m_st; end
              else m_rd = stuck_val;
            end
            if (m_e[83:64] == 20'(CSR_START)) starts_seen++;
          end
        end
        if (csr_ready_i) begin
          if (zero_lat) begin csr_resp_v_i = 1'b1; csr_resp_data_i = m_rd; end
          else begin pend = 1'b1; pend_data = m_rd; end
        end
      end
      if (done_v_o) begin
        done_yumi_i = 1'b1;
        done_cnt++;
        if (exp_done.size() == 0) chk("done_unexp", exp_done.size(), 1);
        else begin m_d = exp_done.pop_front(); chk("done", {done_id_o, done_err_o}, m_d); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_csr", {csr_v_o, csr_w_o, csr_addr_o, csr_data_o}, 0);
    chk("rst_done", {done_v_o, done_err_o, done_id_o}, 0);
    reset_n_i = 1'b1;
    @(negedge clk);

    // Fairness: everyone requests, zero-latency responses.
    zero_lat = 1'b1;
    for (int r = 0; r < N; r++)
      set_desc(r, AW'(39'h100 * (r + 1)), AW'(39'h2000 + r), AW'(39'h7_0000 + r), 4'(r + 1));
    for (int j = 0; j < 5; j++) begin
      push_job(ord[j], AW'(39'h100 * (ord[j] + 1)), AW'(39'h2000 + ord[j]),
               AW'(39'h7_0000 + ord[j]), 4'(ord[j] + 1), 2, 1'b0);
      status_q.push_back(STATUS_BUSY);
      status_q.push_back(STATUS_DONE);
    end
    req_v_i = '1;
    for (int j = 0; j < 5; j++) begin
      wait_grant(N'(1 << ord[j]));
      @(posedge clk); #1;
      if (j >= 1) req_v_i[ord[j]] = 1'b0;
    end
    wait_done(5);

    // Single job, one-cycle responses.
    zero_lat = 1'b0;
    set_desc(2, 39'h8000_1000, 39'h8000_2000, 39'h8000_3000, 4'd8);
    push_job(2, 39'h8000_1000, 39'h8000_2000, 39'h8000_3000, 4'd8, 3, 1'b0);
    status_q.push_back(STATUS_BUSY); status_q.push_back(STATUS_BUSY); status_q.push_back(STATUS_DONE);
    submit(2);
    wait_done(6);

    // Backpressure on the LEN write.
    bp_armed = 1'b1;
    set_desc(1, 39'h40_0000, 39'h41_0000, 39'h42_0000, 4'd5);
    push_job(1, 39'h40_0000, 39'h41_0000, 39'h42_0000, 4'd5, 2, 1'b0);
    status_q.push_back(STATUS_BUSY); status_q.push_back(STATUS_DONE);
    submit(1);
    wait_done(7);
    chk("bp_consumed", bp_armed, 1'b0);

    // Illegal lengths complete at once with error and no CSR traffic.
    set_desc(3, 39'h1, 39'h2, 39'h3, 4'd0);
    exp_done.push_back({2'd3, 1'b1});
    submit(3);
    wait_done(8);
    set_desc(0, 39'h1, 39'h2, 39'h3, 4'd9);
    exp_done.push_back({2'd0, 1'b1});
    submit(0);
    wait_done(9);

    // Tile reports idle before ever going busy: not a completion.
    zero_lat = 1'b1;
    set_desc(0, 39'h55_5000, 39'h66_6000, 39'h77_7000, 4'd1);
    push_job(0, 39'h55_5000, 39'h66_6000, 39'h77_7000, 4'd1, 3, 1'b0);
    status_q.push_back(STATUS_IDLE); status_q.push_back(STATUS_BUSY); status_q.push_back(STATUS_DONE);
    submit(0);
    wait_done(10);

    // Status stuck busy: exactly timeout_p reads then error.
    zero_lat = 1'b0;
    stuck_val = STATUS_BUSY;
    set_desc(3, 39'h3_0000, 39'h3_1000, 39'h3_2000, 4'd7);
    push_job(3, 39'h3_0000, 39'h3_1000, 39'h3_2000, 4'd7, 16, 1'b1);
    submit(3);
    wait_done(11);

    // Reset while waiting between polls; pointer would otherwise sit at 2.
    begin
      int s0, n;
      s0 = starts_seen; n = 0;
      set_desc(1, 39'h9_0000, 39'h9_1000, 39'h9_2000, 4'd3);
      push_job(1, 39'h9_0000, 39'h9_1000, 39'h9_2000, 4'd3, 0, 1'b0);
      submit(1);
      while (starts_seen == s0 && n < 500) begin @(negedge clk); n++; end
      chk("start_seen", starts_seen, s0 + 1);
      repeat (2) @(negedge clk);
      #2 reset_n_i = 1'b0;
      #1;
      chk("arst_csr", {csr_v_o, csr_w_o, csr_addr_o, csr_data_o}, 0);
      chk("arst_done", {done_v_o, done_err_o, done_id_o}, 0);
      chk("arst_ready", req_ready_o, 0);
      exp_cmd.delete(); exp_done.delete(); status_q.delete();
      repeat (3) @(negedge clk);
      reset_n_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {csr_v_o, done_v_o}, 0);
    end
    set_desc(1, 39'hA_0000, 39'hA_1000, 39'hA_2000, 4'd2);
    set_desc(3, 39'hB_0000, 39'hB_1000, 39'hB_2000, 4'd2);
    push_job(1, 39'hA_0000, 39'hA_1000, 39'hA_2000, 4'd2, 2, 1'b0);
    status_q.push_back(STATUS_BUSY); status_q.push_back(STATUS_DONE);
    req_v_i[1] = 1'b1; req_v_i[3] = 1'b1;
    wait_grant(4'b0010);
    @(posedge clk); #1;
    req_v_i = '0;
    wait_done(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
